// File: rtl/crc24_attach_pkg.sv
// Shared constants for the CRC24 attachment stage and the turbo interleaver.
// Block sizes, CRC polynomials, FSM encodings and the serial CRC step.
package crc24_attach_pkg;

    localparam int K_SMALL = 1056;
    localparam int K_LARGE = 6144;
    localparam int CRC_LEN = 24;
    localparam int CNT_W   = 13;

    localparam logic [23:0] CRC24A = 24'h864CFB;
    localparam logic [23:0] CRC24B = 24'h800063;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CRC     = 2'd2;

    // Galois MSB-first step: x^24 is implied by the feedback bit.
    function automatic logic [23:0] crc_step(
        input logic [23:0] c,
        input logic        b,
        input logic [23:0] poly
    );
        logic fb;
        fb = c[23] ^ b;
        return {c[22:0], 1'b0} ^ (fb ? poly : 24'h0);
    endfunction

endpackage

// File: rtl/crc24_attach_if.sv
// Payload-in / framed-bit-out bundle of the CRC24 attachment stage.
// slave is the stage side, master the upstream/downstream side.
interface crc24_attach_if;

    logic in_valid;
    logic in_bit;
    logic in_start;
    logic in_blocksize;
    logic in_ready;
    logic data_out;
    logic data_valid;
    logic CRC_start;
    logic CRC_blocksize;
    logic CRC_end;
    logic err;

    modport slave (
        input  in_valid, in_bit, in_start, in_blocksize,
        output in_ready, data_out, data_valid,
        output CRC_start, CRC_blocksize, CRC_end, err
    );

    modport master (
        output in_valid, in_bit, in_start, in_blocksize,
        input  in_ready, data_out, data_valid,
        input  CRC_start, CRC_blocksize, CRC_end, err
    );

endinterface

// File: rtl/crc24_attach_lfsr.sv
// Serial CRC24 register: init folds the first bit onto CRC_INIT,
// shift_out drains the remainder MSB first.
module crc24_lfsr #(
    parameter logic [23:0] CRC_POLY = 24'h864CFB,
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        data_bit,
    input  logic        shift_out,
    output logic [23:0] crc
);
    import crc24_attach_pkg::*;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_step(init ? CRC_INIT : crc, data_bit, CRC_POLY);
        end else if (shift_out) begin
            crc <= {crc[22:0], 1'b0};
        end
    end

endmodule

// File: rtl/crc24_attach.sv
// LTE transport-block CRC24 attachment: forwards payload bits, appends
// the 24-bit CRC and frames the block for the turbo interleaver.
module crc24_attach #(
    parameter logic [23:0] CRC_POLY = crc24_attach_pkg::CRC24A,
    parameter logic [23:0] CRC_INIT = 24'h000000,
    parameter int          K_SMALL  = crc24_attach_pkg::K_SMALL,
    parameter int          K_LARGE  = crc24_attach_pkg::K_LARGE
) (
    input logic           clk,
    input logic           reset,
    crc24_attach_if.slave bus
);
    import crc24_attach_pkg::*;

    localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(K_SMALL - CRC_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(K_LARGE - CRC_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_LEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      crc;
    logic             start_ok;
    logic             pay_ok;
    logic [CNT_W-1:0] last_idx;

    assign bus.in_ready = !reset && (state != ST_CRC);
    assign start_ok = (state == ST_IDLE) && bus.in_valid && bus.in_start;
    assign pay_ok   = (state == ST_PAYLOAD) && bus.in_valid;
    assign last_idx = bus.CRC_blocksize ? LAST_L : LAST_S;

    crc24_lfsr #(
        .CRC_POLY(CRC_POLY),
        .CRC_INIT(CRC_INIT)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .init     (start_ok),
        .en       (start_ok || pay_ok),
        .data_bit (bus.in_bit),
        .shift_out(state == ST_CRC),
        .crc      (crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bus.data_out      <= 1'b0;
            bus.data_valid    <= 1'b0;
            bus.CRC_start     <= 1'b0;
            bus.CRC_blocksize <= 1'b0;
            bus.CRC_end       <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            bus.CRC_start <= 1'b0;
            bus.CRC_end   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.data_out      <= start_ok && bus.in_bit;
                    bus.data_valid    <= start_ok;
                    bus.CRC_start     <= start_ok;
                    bus.CRC_blocksize <= start_ok && bus.in_blocksize;
                    if (start_ok) begin
                        bus.err <= 1'b0;
                        cnt     <= CNT_W'(1);
                        state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (bus.in_valid) begin
                        bus.data_out   <= bus.in_bit;
                        bus.data_valid <= 1'b1;
                        if (cnt == last_idx) begin
                            cnt   <= '0;
                            state <= ST_CRC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // A hole in the payload aborts the block without a CRC.
                        bus.err           <= 1'b1;
                        bus.data_out      <= 1'b0;
                        bus.data_valid    <= 1'b0;
                        bus.CRC_blocksize <= 1'b0;
                        cnt               <= '0;
                        state             <= ST_IDLE;
                    end
                end
                ST_CRC: begin
                    bus.data_out   <= crc[23];
                    bus.data_valid <= 1'b1;
                    if (cnt == CRC_LAST) begin
                        bus.CRC_end <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_attach.sv
// Scoreboard bench for crc24_attach: driver pushes expected framed bits,
// a negedge monitor pops and compares every output bit.
module tb_crc24_attach;
    import crc24_attach_pkg::*;

    typedef struct packed {
        logic d;
        logic s;
        logic e;
        logic bs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    crc24_attach_if bus ();

    crc24_attach dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   pl[$];
    int   tests = 0;
    int   fails = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   last_wait = 0;
    int   first_wait = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Remainder of M(x)*x^24 divided by x^24+poly, by long division.
    function automatic logic [23:0] ref_crc(input bit m[$]);
        bit          a[$];
        logic [24:0] g;
        logic [23:0] r;
        g = {1'b1, CRC24A};
        a = m;
        repeat (24) a.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (a[i])
                for (int j = 0; j < 25; j++) a[i+j] ^= g[24-j];
        for (int k = 0; k < 24; k++) r[23-k] = a[m.size()+k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got bit %0b, want none at %0t",
                             bus.data_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_bit", {bus.data_out, bus.CRC_start,
                                      bus.CRC_end, bus.CRC_blocksize}, mon_e);
                end
            end else begin
                run_len = 0;
                check("idle_framing", {bus.CRC_start, bus.CRC_end,
                                       bus.CRC_blocksize}, 0);
            end
        end
    end

    task automatic make_payload(input logic bs, input int mode);
        int n;
        n = bs ? (K_LARGE - CRC_LEN) : (K_SMALL - CRC_LEN);
        pl.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 2) pl.push_back(bit'($urandom_range(0, 1)));
            else           pl.push_back(mode == 1 && i == n - 1);
        end
    endtask

    task automatic drive_bit(input logic b, input logic s, input logic bs);
        int w;
        w = 0;
        bus.in_valid     = 1'b1;
        bus.in_bit       = b;
        bus.in_start     = s;
        bus.in_blocksize = bs;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        last_wait = w;
        if (w >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready low %0d cycles, want <100", w);
        end
        exp_q.push_back({b, s, 1'b0, bs});
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic bs, input int gap_at);
        logic [23:0] c;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == gap_at) begin
                bus.in_valid = 1'b0;
                bus.in_start = 1'b0;
                @(posedge clk);
                #1;
                check("err_set", bus.err, 1);
                check("ready_after_gap", bus.in_ready, 1);
                return;
            end
            drive_bit(pl[i], i == 0, bs);
            if (i == 0) begin
                first_wait = last_wait;
                check("err_clear", bus.err, 0);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        c = ref_crc(pl);
        for (int k = 0; k < 24; k++)
            exp_q.push_back({c[23-k], 1'b0, k == 23, bs});
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic bs;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.in_start     = 1'b0;
        bus.in_blocksize = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.data_out, bus.data_valid, bus.CRC_start,
                                bus.CRC_end, bus.CRC_blocksize, bus.err}, 0);
        check("reset_ready", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_idle", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Small all-zero block, then offer bits while the CRC drains.
        make_payload(1'b0, 0);
        run_block(1'b0, -1);
        bus.in_valid = 1'b1;
        bus.in_start = 1'b0;
        cnt = 0;
        while (!bus.in_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("ready_low_cycles", cnt, 24);
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_drain();

        // Large block ending in a single 1: CRC equals the polynomial.
        make_payload(1'b1, 1);
        run_block(1'b1, -1);
        wait_drain();

        // Back-to-back small blocks.
        max_run = 0;
        make_payload(1'b0, 2);
        run_block(1'b0, -1);
        make_payload(1'b0, 2);
        run_block(1'b0, -1);
        check("b2b_wait", first_wait, 24);
        wait_drain();
        check("b2b_contig", max_run, 2 * K_SMALL);

        // Payload gap after 500 bits, then a clean block.
        make_payload(1'b0, 2);
        run_block(1'b0, 500);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", bus.err, 1);
        wait_drain();
        make_payload(1'b0, 2);
        run_block(1'b0, -1);
        wait_drain();

        // Reset in the middle of the CRC phase.
        make_payload(1'b0, 2);
        run_block(1'b0, -1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_outputs", {bus.data_out, bus.data_valid, bus.CRC_start,
                                   bus.CRC_end, bus.CRC_blocksize, bus.err}, 0);
        check("midreset_ready", bus.in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        make_payload(1'b0, 2);
        run_block(1'b0, -1);
        wait_drain();

        // Randomized blocks with random idle spacing.
        for (int r = 0; r < 4; r++) begin
            bs = ($urandom_range(0, 3) == 0);
            make_payload(bs, 2);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_block(bs, -1);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
